scr_base_l3_bk_cell_retire: RTL and testbench
=============================================

Name: scr_base_l3_bk_cell_retire

Overview:
Downstream stage of the L3 bank response collector. Tracks each transaction cell from allocation until all required snoop acks, CompAcks and DBIDs are collected. Selects one completed cell per handshake, round-robin, and hands it to the bank cell allocator for release. Exports the per-cell busy vector back to the allocator.

Parameters:
CELL_NUM, 16, number of transaction cells in the bank (power of 2, >=2)
CELL_W, $clog2(CELL_NUM), cell index width (derived, not overridden)

Ports:
clk  input  1  bank clock
rst_n  input  1  asynchronous active-low reset
alloc_val_i  input  1  cell allocation strobe
alloc_cell_i  input  CELL_W  index of the allocated cell
alloc_ack_need_i  input  1  cell requires snoop acks
alloc_comp_ack_need_i  input  1  cell requires CompAck
alloc_dbid_need_i  input  1  cell requires DBID response
snp_ack_collected_vect_i  input  CELL_NUM  per-cell level: all snoop acks received
comp_ack_collected_vect_i  input  CELL_NUM  per-cell level: CompAck received
comp_dbid_collected_vect_i  input  CELL_NUM  per-cell level: DBID received
retire_val_o  output  1  cell ready to release
retire_cell_o  output  CELL_W  index of the retiring cell
retire_rdy_i  input  1  allocator accepts the release
cell_busy_vect_o  output  CELL_NUM  per-cell: cell not FREE
alloc_err_o  output  1  one-cycle pulse: allocation to a non-FREE cell

Behaviour:
- Clock and reset: single clock clk; rst_n asynchronous, active-low.
- Reset values: all cells FREE; need flags 0; retire_val_o=0; retire_cell_o=0; cell_busy_vect_o=0; alloc_err_o=0; RR pointer=0.
- Per-cell FSM states: FREE, WAIT, READY, RETIRE. Registered state, one FSM per cell.
- FREE -> WAIT: when alloc_val_i is high and alloc_cell_i matches. The three need flags are latched on the same edge.
- WAIT: the collected vectors are not sampled in the allocation cycle, because the collector's values are stale then.
- WAIT -> READY: when done = (!ack_need | snp_ack) & (!comp_ack_need | comp_ack) & (!dbid_need | dbid). If all needs are 0, the cell goes READY one cycle after entering WAIT.
- READY -> RETIRE: when the arbiter grants the cell. The grant is issued only while no cell is in RETIRE.
- RETIRE -> FREE: on retire_val_o & retire_rdy_i.
- Output register: retire_val_o and retire_cell_o are registered. They are set on the grant edge and held stable until the handshake; retire_cell_o must not change while retire_val_o=1 and retire_rdy_i=0.
- Nominal latency: done true in cycle N -> READY at N+1 -> retire_val_o at N+2.
- Handshake rate: back-to-back retires have one bubble (grant is evaluated after RETIRE->FREE), so maximum throughput is one release per 2 cycles.
- Arbitration: round-robin over READY cells. The search starts at ptr; after a grant, ptr = granted+1 mod CELL_NUM, with wrap-around from CELL_NUM-1 to 0.
- cell_busy_vect_o[i] = (state[i] != FREE), registered view of state.
- alloc_err_o: allocation to a cell not in FREE, including a cell whose retire handshake completes in the same cycle. The allocation is ignored, the cell state is unchanged, and alloc_err_o pulses the next cycle.
- Collected vector falling mid-WAIT: not an error; the cell stays in WAIT. Once in READY a cell stays READY regardless of the vectors.
- Reset mid-operation: all state is dropped immediately, including a pending retire_val_o; no release is issued.

Decomposition:
- Shared package scr_base_l3_pkg: SCR_BASE_L3_BK_CELL_NUM constant, and the cell state enum type_scr_base_l3_bk_cell_state_e (FREE/WAIT/READY/RETIRE).
- Sub-module scr_base_l3_bk_rr_arb: parameterised CELL_NUM round-robin arbiter; request vector in, one-hot grant and index out, pointer update on an enable input.

Test Plan:
- Allocate cell 3 with all needs 0; retire_rdy_i=1 -> retire_val_o=1 with retire_cell_o=3 two cycles after allocation; busy[3]=0 the cycle after the handshake.
- Allocate cell 5 with ack_need=1 and dbid_need=1; raise dbid at T and snp_ack at T+4 -> retire_val_o rises at T+6, not before.
- Cells 1, 2, 15 READY in the same cycle, ptr=2 -> retire order 2, 15, 1 (wrap); retire_cell_o is stable while retire_rdy_i=0 for 5 cycles.
- Allocate cell 7 while it is WAIT -> alloc_err_o pulses one cycle; the latched need flags of cell 7 are unchanged.
- Allocate cell 4 with comp_ack_need=1, comp_ack_collected_vect_i[4] stale-high in the allocation cycle, falling the next cycle -> cell 4 stays WAIT; it retires only after the vector rises again.
- Assert rst_n=0 while retire_val_o=1 -> retire_val_o=0 and cell_busy_vect_o=0 asynchronously; no handshake is issued after release of reset.

Source files
------------

// File: rtl/scr_base_l3_pkg.sv
// Shared definitions for the L3 bank cell-tracking logic.
package scr_base_l3_pkg;

   localparam int SCR_BASE_L3_BK_CELL_NUM = 16;

   typedef enum logic [1:0] {
      CELL_FREE   = 2'd0,
      CELL_WAIT   = 2'd1,
      CELL_READY  = 2'd2,
      CELL_RETIRE = 2'd3
   } type_scr_base_l3_bk_cell_state_e;

endpackage

// File: rtl/scr_base_l3_bk_rr_arb.sv
// Round-robin arbiter: picks the first request at or after the pointer and
// moves the pointer past the winner when the grant is consumed.
module scr_base_l3_bk_rr_arb #(
   parameter  int CELL_NUM = 16,
   localparam int CELL_W   = $clog2(CELL_NUM)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [CELL_NUM-1:0] req_i,
   input  logic                en_i,
   output logic                gnt_val_o,
   output logic [CELL_NUM-1:0] gnt_oh_o,
   output logic [CELL_W-1:0]   gnt_idx_o
);

   logic [CELL_W-1:0] ptr_q;
   logic [CELL_W-1:0] ptr_d;
   logic [CELL_W-1:0] idx;

   // Walk from the farthest candidate back to ptr so the nearest request wins.
   always_comb begin
      gnt_val_o = 1'b0;
      gnt_idx_o = '0;
      idx       = '0;
      for (int k = CELL_NUM - 1; k >= 0; k--) begin
         idx = ptr_q + CELL_W'(k);
         if (req_i[idx]) begin
            gnt_val_o = 1'b1;
            gnt_idx_o = idx;
         end
      end
   end

   assign gnt_oh_o = gnt_val_o ? (CELL_NUM'(1) << gnt_idx_o) : '0;

   always_comb begin
      ptr_d = ptr_q;
      if (en_i && gnt_val_o) begin
         ptr_d = gnt_idx_o + CELL_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/scr_base_l3_bk_cell_retire.sv
// Retire stage of the L3 bank response collector: tracks each cell until its
// responses are collected and releases finished cells one handshake at a time.
module scr_base_l3_bk_cell_retire
   import scr_base_l3_pkg::*;
#(
   parameter  int CELL_NUM = SCR_BASE_L3_BK_CELL_NUM,
   localparam int CELL_W   = $clog2(CELL_NUM)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                alloc_val_i,
   input  logic [CELL_W-1:0]   alloc_cell_i,
   input  logic                alloc_ack_need_i,
   input  logic                alloc_comp_ack_need_i,
   input  logic                alloc_dbid_need_i,
   input  logic [CELL_NUM-1:0] snp_ack_collected_vect_i,
   input  logic [CELL_NUM-1:0] comp_ack_collected_vect_i,
   input  logic [CELL_NUM-1:0] comp_dbid_collected_vect_i,
   output logic                retire_val_o,
   output logic [CELL_W-1:0]   retire_cell_o,
   input  logic                retire_rdy_i,
   output logic [CELL_NUM-1:0] cell_busy_vect_o,
   output logic                alloc_err_o
);

   type_scr_base_l3_bk_cell_state_e state_q [CELL_NUM];
   type_scr_base_l3_bk_cell_state_e state_d [CELL_NUM];

   logic [CELL_NUM-1:0] ack_need_q,  ack_need_d;
   logic [CELL_NUM-1:0] comp_need_q, comp_need_d;
   logic [CELL_NUM-1:0] dbid_need_q, dbid_need_d;

   logic [CELL_NUM-1:0] ready_vect;
   logic [CELL_NUM-1:0] retire_vect;
   logic [CELL_NUM-1:0] done_vect;
   logic [CELL_NUM-1:0] busy_vect;
   logic [CELL_NUM-1:0] gnt_oh;
   logic [CELL_W-1:0]   gnt_idx;
   logic                arb_gnt_val;
   logic                grant_val;
   logic                handshake;
   logic                alloc_free;

   logic                retire_val_q,  retire_val_d;
   logic [CELL_W-1:0]   retire_cell_q, retire_cell_d;
   logic                alloc_err_q,   alloc_err_d;

   always_comb begin
      for (int i = 0; i < CELL_NUM; i++) begin
         ready_vect[i]  = (state_q[i] == CELL_READY);
         retire_vect[i] = (state_q[i] == CELL_RETIRE);
         busy_vect[i]   = (state_q[i] != CELL_FREE);
         done_vect[i]   = (!ack_need_q[i]  | snp_ack_collected_vect_i[i]) &
                          (!comp_need_q[i] | comp_ack_collected_vect_i[i]) &
                          (!dbid_need_q[i] | comp_dbid_collected_vect_i[i]);
      end
   end

   // Only one cell may sit in RETIRE, so a new grant waits for the release edge.
   assign grant_val  = arb_gnt_val & ~(|retire_vect);
   assign handshake  = retire_val_q & retire_rdy_i;
   assign alloc_free = alloc_val_i & (state_q[alloc_cell_i] == CELL_FREE);

   scr_base_l3_bk_rr_arb #(
      .CELL_NUM (CELL_NUM)
   ) u_rr_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_i     (ready_vect),
      .en_i      (grant_val),
      .gnt_val_o (arb_gnt_val),
      .gnt_oh_o  (gnt_oh),
      .gnt_idx_o (gnt_idx)
   );

   always_comb begin
      for (int i = 0; i < CELL_NUM; i++) begin
         state_d[i] = state_q[i];
         unique case (state_q[i])
            CELL_FREE:   if (alloc_free && (alloc_cell_i == CELL_W'(i))) state_d[i] = CELL_WAIT;
            CELL_WAIT:   if (done_vect[i])                 state_d[i] = CELL_READY;
            CELL_READY:  if (grant_val && gnt_oh[i])       state_d[i] = CELL_RETIRE;
            CELL_RETIRE: if (handshake)                    state_d[i] = CELL_FREE;
            default:                                       state_d[i] = CELL_FREE;
         endcase
      end
   end

   always_comb begin
      ack_need_d  = ack_need_q;
      comp_need_d = comp_need_q;
      dbid_need_d = dbid_need_q;
      if (alloc_free) begin
         ack_need_d[alloc_cell_i]  = alloc_ack_need_i;
         comp_need_d[alloc_cell_i] = alloc_comp_ack_need_i;
         dbid_need_d[alloc_cell_i] = alloc_dbid_need_i;
      end
   end

   always_comb begin
      retire_val_d  = retire_val_q;
      retire_cell_d = retire_cell_q;
      if (grant_val) begin
         retire_val_d  = 1'b1;
         retire_cell_d = gnt_idx;
      end else if (handshake) begin
         retire_val_d  = 1'b0;
      end
   end

   assign alloc_err_d = alloc_val_i & (state_q[alloc_cell_i] != CELL_FREE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= '{default: CELL_FREE};
         ack_need_q    <= '0;
         comp_need_q   <= '0;
         dbid_need_q   <= '0;
         retire_val_q  <= 1'b0;
         retire_cell_q <= '0;
         alloc_err_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         ack_need_q    <= ack_need_d;
         comp_need_q   <= comp_need_d;
         dbid_need_q   <= dbid_need_d;
         retire_val_q  <= retire_val_d;
         retire_cell_q <= retire_cell_d;
         alloc_err_q   <= alloc_err_d;
      end
   end

   assign retire_val_o     = retire_val_q;
   assign retire_cell_o    = retire_cell_q;
   assign alloc_err_o      = alloc_err_q;
   assign cell_busy_vect_o = busy_vect;

endmodule

// File: tb/tb_scr_base_l3_bk_cell_retire.sv
// Bench for the L3 bank cell retire stage: directed scenarios followed by a
// random phase, all checked against a cycle-level reference model.
module tb_scr_base_l3_bk_cell_retire;

   localparam int N = 16;
   localparam int M_FREE = 0, M_WAIT = 1, M_READY = 2, M_RETIRE = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          alloc_val_i;
   logic [3:0]    alloc_cell_i;
   logic          alloc_ack_need_i, alloc_comp_ack_need_i, alloc_dbid_need_i;
   logic [N-1:0]  snp_v, comp_v, dbid_v;
   logic          retire_val_o;
   logic [3:0]    retire_cell_o;
   logic          retire_rdy_i;
   logic [N-1:0]  cell_busy_vect_o;
   logic          alloc_err_o;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: per-cell status and need flags, plus the output port view.
   int ms [N];
   bit ma [N];
   bit mc [N];
   bit md [N];
   int mptr;
   bit mval;
   int mcell;
   bit merr;

   scr_base_l3_bk_cell_retire #(.CELL_NUM(N)) dut (
      .clk                        (clk),
      .rst_n                      (rst_n),
      .alloc_val_i                (alloc_val_i),
      .alloc_cell_i               (alloc_cell_i),
      .alloc_ack_need_i           (alloc_ack_need_i),
      .alloc_comp_ack_need_i      (alloc_comp_ack_need_i),
      .alloc_dbid_need_i          (alloc_dbid_need_i),
      .snp_ack_collected_vect_i   (snp_v),
      .comp_ack_collected_vect_i  (comp_v),
      .comp_dbid_collected_vect_i (dbid_v),
      .retire_val_o               (retire_val_o),
      .retire_cell_o              (retire_cell_o),
      .retire_rdy_i               (retire_rdy_i),
      .cell_busy_vect_o           (cell_busy_vect_o),
      .alloc_err_o                (alloc_err_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [N-1:0] m_busy();
      logic [N-1:0] b;
      for (int i = 0; i < N; i++) b[i] = (ms[i] != M_FREE);
      return b;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         ms[i] = M_FREE; ma[i] = 0; mc[i] = 0; md[i] = 0;
      end
      mptr = 0; mval = 0; mcell = 0; merr = 0;
   endtask

   // Advance the model by one clock using the inputs currently applied.
   task automatic model_step();
      int nxt [N];
      int g;
      bit hs;
      bit anyret;
      hs = mval && retire_rdy_i;
      anyret = 0;
      for (int i = 0; i < N; i++) if (ms[i] == M_RETIRE) anyret = 1;
      g = -1;
      if (!anyret) begin
         for (int k = 0; k < N; k++) begin
            int c;
            c = (mptr + k) % N;
            if (g < 0 && ms[c] == M_READY) g = c;
         end
      end
      merr = alloc_val_i && (ms[int'(alloc_cell_i)] != M_FREE);
      for (int i = 0; i < N; i++) begin
         nxt[i] = ms[i];
         case (ms[i])
            M_FREE: if (alloc_val_i && int'(alloc_cell_i) == i) begin
               nxt[i] = M_WAIT;
               ma[i] = alloc_ack_need_i; mc[i] = alloc_comp_ack_need_i; md[i] = alloc_dbid_need_i;
            end
            M_WAIT: if ((!ma[i] || snp_v[i]) && (!mc[i] || comp_v[i]) && (!md[i] || dbid_v[i]))
               nxt[i] = M_READY;
            M_READY: if (i == g) nxt[i] = M_RETIRE;
            default: if (hs) nxt[i] = M_FREE;
         endcase
      end
      for (int i = 0; i < N; i++) ms[i] = nxt[i];
      if (g >= 0) begin
         mval = 1; mcell = g; mptr = (g + 1) % N;
      end else if (hs) begin
         mval = 0;
      end
   endtask

   task automatic cyc();
      model_step();
      @(posedge clk);
      #1;
      chk("retire_val", 32'(retire_val_o), 32'(mval));
      if (mval) chk("retire_cell", 32'(retire_cell_o), 32'(mcell));
      chk("busy_vect", 32'(cell_busy_vect_o), 32'(m_busy()));
      chk("alloc_err", 32'(alloc_err_o), 32'(merr));
   endtask

   task automatic alloc(input int c, input bit a, input bit cp, input bit d);
      alloc_val_i = 1'b1;
      alloc_cell_i = 4'(c);
      alloc_ack_need_i = a;
      alloc_comp_ack_need_i = cp;
      alloc_dbid_need_i = d;
      cyc();
      alloc_val_i = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      alloc_val_i = 0; alloc_cell_i = '0;
      alloc_ack_need_i = 0; alloc_comp_ack_need_i = 0; alloc_dbid_need_i = 0;
      snp_v = '0; comp_v = '0; dbid_v = '0;
      retire_rdy_i = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_retire_val", 32'(retire_val_o), 32'd0);
      chk("rst_retire_cell", 32'(retire_cell_o), 32'd0);
      chk("rst_busy", 32'(cell_busy_vect_o), 32'd0);
      chk("rst_alloc_err", 32'(alloc_err_o), 32'd0);
      rst_n = 1'b1;

      // Cell 3 with no needs: released two cycles after it enters WAIT.
      alloc(3, 0, 0, 0);
      cyc();
      chk("t1_early", 32'(retire_val_o), 32'd0);
      cyc();
      chk("t1_val", 32'(retire_val_o), 32'd1);
      chk("t1_cell", 32'(retire_cell_o), 32'd3);
      cyc();
      chk("t1_busy3", 32'(cell_busy_vect_o[3]), 32'd0);

      // Cell 5 needs snoop acks and DBID; DBID at T, acks at T+4.
      alloc(5, 1, 0, 1);
      cyc(); cyc();
      dbid_v[5] = 1'b1;
      for (int k = 0; k < 4; k++) begin
         cyc();
         chk("t2_hold", 32'(retire_val_o), 32'd0);
      end
      snp_v[5] = 1'b1;
      cyc();
      chk("t2_ready_no_val", 32'(retire_val_o), 32'd0);
      cyc();
      chk("t2_val", 32'(retire_val_o), 32'd1);
      chk("t2_cell", 32'(retire_cell_o), 32'd5);
      cyc();
      snp_v = '0; dbid_v = '0;

      // Retire cell 1 to bring the pointer to 2, then race cells 1, 2 and 15.
      alloc(1, 0, 0, 0);
      cyc(); cyc(); cyc();
      retire_rdy_i = 1'b0;
      alloc(1, 1, 0, 0);
      alloc(2, 1, 0, 0);
      alloc(15, 1, 0, 0);
      snp_v = 16'h8006;
      cyc();
      cyc();
      chk("t3_first", 32'(retire_cell_o), 32'd2);
      for (int k = 0; k < 5; k++) begin
         cyc();
         chk("t3_stable_val", 32'(retire_val_o), 32'd1);
         chk("t3_stable_cell", 32'(retire_cell_o), 32'd2);
      end
      retire_rdy_i = 1'b1;
      cyc();
      chk("t3_bubble1", 32'(retire_val_o), 32'd0);
      cyc();
      chk("t3_second", 32'(retire_cell_o), 32'd15);
      cyc();
      chk("t3_bubble2", 32'(retire_val_o), 32'd0);
      cyc();
      chk("t3_third_val", 32'(retire_val_o), 32'd1);
      chk("t3_third", 32'(retire_cell_o), 32'd1);
      cyc();
      snp_v = '0;

      // Second allocation of a WAIT cell is rejected and keeps its needs.
      alloc(7, 1, 0, 0);
      alloc(7, 0, 0, 0);
      chk("t4_err", 32'(alloc_err_o), 32'd1);
      cyc();
      chk("t4_err_pulse", 32'(alloc_err_o), 32'd0);
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk("t4_busy7", 32'(cell_busy_vect_o[7]), 32'd1);
         chk("t4_no_val", 32'(retire_val_o), 32'd0);
      end
      snp_v[7] = 1'b1;
      cyc(); cyc();
      chk("t4_cell", 32'(retire_cell_o), 32'd7);
      cyc();
      snp_v = '0;

      // Stale-high CompAck in the allocation cycle must not complete cell 4.
      comp_v[4] = 1'b1;
      alloc(4, 0, 1, 0);
      comp_v[4] = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk("t5_wait_busy", 32'(cell_busy_vect_o[4]), 32'd1);
         chk("t5_wait_val", 32'(retire_val_o), 32'd0);
      end
      comp_v[4] = 1'b1;
      cyc(); cyc();
      chk("t5_cell", 32'(retire_cell_o), 32'd4);
      alloc(4, 0, 0, 0);
      chk("t5_err_on_release", 32'(alloc_err_o), 32'd1);
      chk("t5_freed", 32'(cell_busy_vect_o[4]), 32'd0);
      comp_v = '0;

      // Asynchronous reset while a release is pending.
      retire_rdy_i = 1'b0;
      alloc(9, 0, 0, 0);
      cyc(); cyc();
      chk("t6_pending", 32'(retire_val_o), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_async_val", 32'(retire_val_o), 32'd0);
      chk("t6_async_busy", 32'(cell_busy_vect_o), 32'd0);
      model_reset();
      retire_rdy_i = 1'b1;
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         cyc();
         chk("t6_no_release", 32'(retire_val_o), 32'd0);
      end

      // Random traffic against the model.
      for (int k = 0; k < 400; k++) begin
         alloc_val_i = ($urandom_range(0, 1) == 1);
         alloc_cell_i = 4'($urandom_range(0, N - 1));
         alloc_ack_need_i = ($urandom_range(0, 3) == 0);
         alloc_comp_ack_need_i = ($urandom_range(0, 3) == 0);
         alloc_dbid_need_i = ($urandom_range(0, 3) == 0);
         snp_v = 16'($urandom);
         comp_v = 16'($urandom);
         dbid_v = 16'($urandom);
         retire_rdy_i = ($urandom_range(0, 3) != 0);
         cyc();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
